shift_reg_par_in_serial_out: RTL and testbench
==============================================

# shift_reg_par_in_serial_out

Parallel-in, serial-out shifter with load handshake and frame control. Accepts an M-bit word from an upstream producer, then emits it LSB-first one bit per `shift` strobe. The downstream serial-in/parallel-out register of the same width reassembles the word unchanged. The block sits on the transmit side of the team's bit-serial links, between a word source and a bit-rate pacing tick.

## Interface
- `M`, default 5: data word width in bits, M ≥ 2.
- `clk` input, 1 bit: rising-edge clock.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `byte_in` input, M bits: parallel word to send, sampled on load handshake.
- `load_valid` input, 1 bit: producer offers `byte_in`.
- `load_ready` output, 1 bit: block can accept a word this cycle.
- `shift` input, 1 bit: downstream consumed current `bit_out`; advance.
- `bit_out` output, 1 bit: current serial bit.
- `bit_valid` output, 1 bit: `bit_out` holds a frame bit.
- `busy` output, 1 bit: frame in progress.
- `done` output, 1 bit: one-cycle pulse after the last frame bit is consumed.

## Operation
- FSM states: IDLE, SHIFT.
- Internal: M-bit shift register `sr`, bit counter `cnt` (width `$clog2(F+1)`, where F is the frame length: F = M by default).
- IDLE: `load_ready`=1, `bit_valid`=0, `busy`=0, `bit_out`=0. On `load_valid`, load `sr`←`byte_in`, `cnt`←0, go to SHIFT.
- SHIFT: `bit_valid`=1, `busy`=1, `bit_out`=`sr[0]`. On `shift`, `sr`←{1'b0, `sr[M-1:1]`} and `cnt`←`cnt`+1. Without `shift`, all state holds; stall length is unbounded.
- Last bit is the bit presented while `cnt`=F-1. `shift` on the last bit:
  - `done`=1 on the following cycle.
  - If `load_valid` is also 1, reload `sr` and `cnt`←0 and stay in SHIFT. This gives back-to-back frames with no bubble.
  - Otherwise go to IDLE.
- `load_ready` = IDLE, or (SHIFT and last bit and `shift`). It is combinational on `shift`.
- `load_valid` in SHIFT outside the last-bit shift cycle is ignored. The word is not captured and the producer holds it.
- `shift` in IDLE is ignored.
- Reset, including mid-frame: state→IDLE, `sr`←0, `cnt`←0, `done`←0. The partial frame is dropped and no `done` is issued.

## Timing
- Load handshake at edge N → first bit valid on `bit_out` from edge N to edge N+1.
- Minimum frame: F cycles with `shift` held high. `done` is high for the cycle after edge N+F.
- Throughput with continuous `shift` and `load_valid`: one word per F cycles.
- All outputs except `load_ready` are registered. All reset values are 0, except `load_ready`, which is 1 once reset is released (IDLE).

## Configuration
- Macro `PISO_PARITY_EN`:
  - Defined: frame length F = M+1. After the M data bits, one even-parity bit (XOR of the loaded word, captured at load) is presented in SHIFT with `bit_valid`=1. `done` follows its consumption.
  - Undefined: F = M; no parity logic is present.

## Structure
- Package `piso_pkg`:
  - state enum `piso_state_t` {IDLE, SHIFT};
  - function `frame_len(M)` returning M or M+1 per `PISO_PARITY_EN`;
  - localparam-friendly counter width helper.
- One sub-module, `piso_bit_counter`: counts strobes up to F-1, with clear and enable inputs and a `last` output.

## Test plan
- M=5, load 5'b10110, `shift` held high → `bit_out` sequence 0,1,1,0,1 on 5 consecutive cycles; `done` pulses once; returns to IDLE.
- Same word, `shift` asserted every 3rd cycle → identical bit sequence; `bit_out` stable during stalls; `done` only after the 5th strobe.
- Words 5'h15 then 5'h0A, `load_valid` held → second load accepted in the last-bit shift cycle; no cycle with `bit_valid`=0 between frames; `done` pulses twice.
- `reset_n` low after 2 shifts of 5'h1F → outputs 0 asynchronously; after release `load_ready`=1; no `done`.
- `PISO_PARITY_EN`, load 5'b10110 → 6 bits 0,1,1,0,1,1; load 5'b00011 → trailing parity bit 0.
- Loopback into a width-M serial-in/parallel-out register on matching strobes, 100 random words → received word equals sent word after each `done`.

Source files
------------

// File: rtl/shift_reg_par_in_serial_out_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
//
// Shared types and helpers for the parallel-in / serial-out transmit shifter.
//
// Contents:
//   piso_state_t - FSM state encoding (IDLE, SHIFT)
//   frame_len()  - number of serial bits per frame for a word width M
//   cnt_width()  - bit width of a counter that must hold values 0..f
//
// Configuration macro: PISO_PARITY_EN
//   When defined, every frame carries one trailing even-parity bit.
//   The frame is then M+1 bits long instead of M.
// ---------------------------------------------------------------------------
package piso_pkg;

  // Two-state frame controller: waiting for a word, or sending one.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Serial bits per frame.
  // This is the data bits, plus the parity bit when that option is built in.
  function automatic int frame_len(input int m);
`ifdef PISO_PARITY_EN
    return m + 1;
`else
    return m;
`endif
  endfunction

  // Width needed for a counter that can represent 0..f inclusive.
  // It is usable in localparam expressions.
  function automatic int cnt_width(input int f);
    return $clog2(f + 1);
  endfunction

endpackage

// File: rtl/shift_reg_par_in_serial_out_if.sv
// ---------------------------------------------------------------------------
// shift_reg_par_in_serial_out_if
//
// Bundles the load handshake and the serial output side of the PISO shifter.
//
// Signals:
//   byte_in    [M-1:0] parallel word offered by the producer
//   load_valid         producer offers byte_in
//   load_ready         shifter accepts a word this cycle (combinational)
//   shift              consumer has taken bit_out, advance to the next bit
//   bit_out            current serial bit
//   bit_valid          bit_out carries a frame bit
//   busy               a frame is in progress
//   done               one-cycle pulse after the last frame bit is consumed
//
// Modports:
//   master - producer/consumer side (drives byte_in, load_valid, shift)
//   slave  - the shifter itself
//
// Configuration macro: none (frame length is decided inside the shifter).
// ---------------------------------------------------------------------------
interface shift_reg_par_in_serial_out_if #(
  parameter int M = 5
);

  logic [M-1:0] byte_in;
  logic         load_valid;
  logic         load_ready;
  logic         shift;
  logic         bit_out;
  logic         bit_valid;
  logic         busy;
  logic         done;

  // Environment side: supplies words and paces the serial stream.
  modport master (
    output byte_in,
    output load_valid,
    output shift,
    input  load_ready,
    input  bit_out,
    input  bit_valid,
    input  busy,
    input  done
  );

  // Shifter side.
  modport slave (
    input  byte_in,
    input  load_valid,
    input  shift,
    output load_ready,
    output bit_out,
    output bit_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/shift_reg_par_in_serial_out_bit_counter.sv
// ---------------------------------------------------------------------------
// piso_bit_counter
//
// Counts consumed serial bits within a frame. It flags the last bit, at
// count F-1.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset, count returns to 0
//   clear_i   synchronous clear to 0, takes priority over enable_i
//   enable_i  advance the count by one
//   last_o    the bit currently presented is the final bit of the frame
//
// Parameters:
//   F         frame length in bits (>= 2)
//
// Configuration macro: none.
// ---------------------------------------------------------------------------
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int F = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic last_o
);

  localparam int W = cnt_width(F);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over enable.
  // This lets the controller restart the count on the same edge that
  // consumes the last bit of the previous frame.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == W'(F - 1));

endmodule

// File: rtl/shift_reg_par_in_serial_out.sv
// ---------------------------------------------------------------------------
// shift_reg_par_in_serial_out
//
// Transmit-side parallel-in / serial-out shifter.
// It accepts an M-bit word through a valid/ready handshake. It then presents
// the word LSB-first, one bit per shift strobe. A word offered during the
// shift of the last bit is accepted on that edge, so frames run back to back
// with no idle cycle between them.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset. A partial frame is dropped and
//            no done pulse is issued for it.
//   bus      shift_reg_par_in_serial_out_if.slave. It carries byte_in,
//            load_valid, load_ready, shift, bit_out, bit_valid, busy and done.
//
// Parameters:
//   M        data word width (>= 2)
//
// Configuration macro: PISO_PARITY_EN
//   When defined, an even-parity bit of the loaded word follows the M data
//   bits. The parity bit is presented with bit_valid high. done follows the
//   consumption of that parity bit.
// ---------------------------------------------------------------------------
module shift_reg_par_in_serial_out
  import piso_pkg::*;
#(
  parameter int M = 5
) (
  input  logic                            clk,
  input  logic                            reset_n,
  shift_reg_par_in_serial_out_if.slave    bus
);

  localparam int         F       = frame_len(M);
  localparam logic [0:0] StIdle  = 1'(IDLE);
  localparam logic [0:0] StShift = 1'(SHIFT);

  logic [0:0]   state_q;
  logic [0:0]   state_d;
  logic [M-1:0] sr_q;
  logic [M-1:0] sr_d;
  logic         done_q;
  logic         done_d;

  logic         inShift;
  logic         shiftFire;
  logic         lastShift;
  logic         loadReady;
  logic         loadFire;
  logic         cntLast;
  logic         shiftFill;

`ifdef PISO_PARITY_EN
  logic         parity_q;
  logic         parity_d;

  // The parity bit is fed in at the top of the register on every shift.
  // After M shifts it has reached bit 0, so bit_out presents it as the
  // frame's final bit with no extra output mux.
  assign shiftFill = parity_q;
`else
  assign shiftFill = 1'b0;
`endif

  // Handshake qualifiers.
  // A new word may enter when idle, or on the edge that consumes the last
  // bit of the current frame. This makes load_ready combinational on shift.
  assign inShift   = (state_q == StShift);
  assign shiftFire = inShift & bus.shift;
  assign lastShift = shiftFire & cntLast;
  assign loadReady = ~inShift | lastShift;
  assign loadFire  = bus.load_valid & loadReady;

  // Frame controller next state.
  // A load takes priority over ending the frame, which gives back-to-back
  // frames. Leaving SHIFT clears the register so that bit_out reads 0
  // while idle.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    if (loadFire) begin
      state_d = StShift;
      sr_d    = bus.byte_in;
`ifdef PISO_PARITY_EN
      parity_d = ^bus.byte_in;
`endif
    end else if (lastShift) begin
      state_d = StIdle;
      sr_d    = '0;
`ifdef PISO_PARITY_EN
      parity_d = 1'b0;
`endif
    end else if (shiftFire) begin
      sr_d = {shiftFill, sr_q[M-1:1]};
    end
  end

  // done marks the cycle after the final bit was consumed.
  // It is raised whether or not a new frame starts on that same edge.
  always_comb begin
    done_d = lastShift;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      done_q  <= done_d;
    end
  end

`ifdef PISO_PARITY_EN
  // Parity captured at load time, held for the whole frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // Position within the frame.
  // The count restarts on every load and on the final shift, so it is
  // already 0 whenever the controller is idle.
  piso_bit_counter #(
    .F (F)
  ) u_bitCounter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (loadFire | lastShift),
    .enable_i (shiftFire),
    .last_o   (cntLast)
  );

  assign bus.load_ready = loadReady;
  assign bus.bit_out    = sr_q[0];
  assign bus.bit_valid  = inShift;
  assign bus.busy       = inShift;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_shift_reg_par_in_serial_out.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_par_in_serial_out
//
// Directed and randomized stimulus for the PISO shifter.
// A frame-level reference model holds a queue of the bits still to be sent.
// A serial-in/parallel-out loopback register rebuilds each word, which is
// compared with the word that was loaded.
// Build with +define+PISO_PARITY_EN to exercise the parity frame.
// ---------------------------------------------------------------------------
module tb_shift_reg_par_in_serial_out;

  localparam int M = 5;
`ifdef PISO_PARITY_EN
  localparam int F = M + 1;
`else
  localparam int F = M;
`endif

  logic clk;
  logic reset_n;

  shift_reg_par_in_serial_out_if #(.M(M)) busIf ();

  shift_reg_par_in_serial_out #(.M(M)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (busIf)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int           compared   = 0;
  int           mismatched = 0;

  // Reference model state: the bits of the frame still to be presented.
  bit           mBusy;
  bit           mDone;
  bit           mBits[$];
  logic [M-1:0] sentQ[$];
  int           totalLoads = 0;

  // Loopback receiver state.
  logic [M-1:0] rx;
  logic [M-1:0] rxDoneWord;
  int           rxCnt;

  // Observation log for the directed checks.
  int           doneSeen = 0;
  logic [31:0]  seq;
  int           seqN;

  // Compares one observed value with the model's expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Builds the expected serial frame for a word: data bits LSB-first,
  // followed by the even-parity bit when parity is built in.
  task automatic modelLoad(input logic [M-1:0] w);
    mBits.delete();
    for (int i = 0; i < M; i++) mBits.push_back(w[i]);
`ifdef PISO_PARITY_EN
    mBits.push_back(^w);
`endif
    mBusy = 1'b1;
    sentQ.push_back(w);
    totalLoads++;
  endtask

  // Runs one clock cycle with the given inputs, then checks every output.
  // The task is entered just after a rising edge.
  task automatic applyStimulus(input bit lv, input logic [M-1:0] w, input bit sh);
    bit           expReady;
    bit           lastShift;
    bit           wasShift;
    bit           expBit;
    logic [M-1:0] sent;
    busIf.load_valid = lv;
    busIf.byte_in    = w;
    busIf.shift      = sh;
    #1;
    wasShift  = mBusy && sh;
    lastShift = wasShift && (mBits.size() == 1);
    expReady  = !mBusy || lastShift;
    checkOutput("load_ready", 32'(busIf.load_ready), 32'(expReady));
    if (wasShift) begin
      if (seqN < 32) seq[seqN] = busIf.bit_out;
      seqN++;
      if (rxCnt < M) rx = {busIf.bit_out, rx[M-1:1]};
      rxCnt++;
      if (lastShift) begin
        rxDoneWord = rx;
        rxCnt      = 0;
      end
    end
    @(posedge clk);
    if (wasShift) void'(mBits.pop_front());
    if (mBusy && mBits.size() == 0) mBusy = 1'b0;
    if (lv && expReady) modelLoad(w);
    mDone = lastShift;
    #1;
    expBit = mBusy ? mBits[0] : 1'b0;
    checkOutput("bit_valid", 32'(busIf.bit_valid), 32'(mBusy));
    checkOutput("busy", 32'(busIf.busy), 32'(mBusy));
    checkOutput("bit_out", 32'(busIf.bit_out), 32'(expBit));
    checkOutput("done", 32'(busIf.done), 32'(mDone));
    if (busIf.done === 1'b1) doneSeen++;
    if (mDone) begin
      if (sentQ.size() > 0) sent = sentQ.pop_front();
      else sent = 'x;
      checkOutput("loopback", 32'(rxDoneWord), 32'(sent));
    end
  endtask

  // Asserts reset in the middle of a cycle and checks that the outputs clear
  // at once, without waiting for a clock edge.
  task automatic applyReset();
    reset_n = 1'b0;
    busIf.load_valid = 1'b0;
    busIf.shift      = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busIf.busy), 32'd0);
    checkOutput("rst_bit_valid", 32'(busIf.bit_valid), 32'd0);
    checkOutput("rst_bit_out", 32'(busIf.bit_out), 32'd0);
    checkOutput("rst_done", 32'(busIf.done), 32'd0);
    mBusy = 1'b0;
    mDone = 1'b0;
    mBits.delete();
    sentQ.delete();
    rxCnt = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    checkOutput("rst_release_ready", 32'(busIf.load_ready), 32'd1);
  endtask

  initial begin
    int doneBase;
    int iters;
    int cycles;
    logic [31:0] expSeq;

    reset_n          = 1'b0;
    busIf.load_valid = 1'b0;
    busIf.byte_in    = '0;
    busIf.shift      = 1'b0;
    mBusy = 1'b0;
    mDone = 1'b0;
    rx    = '0;
    rxDoneWord = '0;
    rxCnt = 0;
    seq   = '0;
    seqN  = 0;

    // Reset state.
    #12;
    checkOutput("reset_busy", 32'(busIf.busy), 32'd0);
    checkOutput("reset_bit_valid", 32'(busIf.bit_valid), 32'd0);
    checkOutput("reset_bit_out", 32'(busIf.bit_out), 32'd0);
    checkOutput("reset_done", 32'(busIf.done), 32'd0);
    checkOutput("reset_load_ready", 32'(busIf.load_ready), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;

`ifdef PISO_PARITY_EN
    expSeq = 32'b110110;
`else
    expSeq = 32'b10110;
`endif

    // Word 10110 with shift held high.
    $display("[TB] continuous shift");
    doneBase = doneSeen;
    seq = '0; seqN = 0;
    applyStimulus(1'b1, 5'b10110, 1'b0);
    repeat (F) applyStimulus(1'b0, '0, 1'b1);
    repeat (2) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("cont_sequence", seq, expSeq);
    checkOutput("cont_done_count", 32'(doneSeen - doneBase), 32'd1);

    // Same word, shift on every third cycle.
    $display("[TB] stalled shift");
    doneBase = doneSeen;
    seq = '0; seqN = 0;
    applyStimulus(1'b1, 5'b10110, 1'b0);
    for (int i = 0; i < 3 * F + 3; i++) applyStimulus(1'b0, '0, (i % 3) == 2);
    checkOutput("stall_sequence", seq, expSeq);
    checkOutput("stall_done_count", 32'(doneSeen - doneBase), 32'd1);

    // Back-to-back frames: 15h then 0Ah, with load_valid held.
    $display("[TB] back-to-back frames");
    doneBase = doneSeen;
    applyStimulus(1'b1, 5'h15, 1'b1);
    iters = 0;
    while (totalLoads < 4 && iters < 20) begin
      applyStimulus(1'b1, 5'h0A, 1'b1);
      iters++;
    end
    checkOutput("b2b_accept_cycle", 32'(iters), 32'(F));
    repeat (F + 2) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("b2b_done_count", 32'(doneSeen - doneBase), 32'd2);

    // Reset in mid-frame after two shifts of 1Fh.
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 5'h1F, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b1);
    doneBase = doneSeen;
    applyReset();
    repeat (F + 2) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rst_no_done", 32'(doneSeen - doneBase), 32'd0);

`ifdef PISO_PARITY_EN
    // Trailing parity bit of 00011 is 0.
    $display("[TB] parity word 00011");
    seq = '0; seqN = 0;
    applyStimulus(1'b1, 5'b00011, 1'b0);
    repeat (F + 1) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("parity_sequence", seq, 32'b000011);
`endif

    // Random loopback: 100 words with random valid and random shift pacing.
    $display("[TB] random loopback");
    doneBase = doneSeen;
    iters = totalLoads;
    cycles = 0;
    while (((totalLoads - iters) < 100 || mBusy) && cycles < 5000) begin
      applyStimulus(((totalLoads - iters) < 100) && ($urandom_range(0, 3) != 0),
                    M'($urandom), $urandom_range(0, 9) < 7);
      cycles++;
    end
    checkOutput("rand_loads", 32'(totalLoads - iters), 32'd100);
    checkOutput("rand_done_count", 32'(doneSeen - doneBase), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
